// File: rtl/soc_uart_ctrl_pkg.sv
// soc_uart_pkg: shared definitions for the soc_uart register front-end.
//   - register word addresses on the 2-bit bus
//   - bit positions inside the STATUS and CTRL registers
//   - TX and RX handshake FSM state encodings
// Optional feature macro used by the design: SOC_UART_CTRL_IRQ_EN.
package soc_uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // STATUS bit positions; [6:3] are sticky, write-1-to-clear
  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVF     = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_RX_BREAK   = 5;
  localparam int ST_TX_OVF     = 6;

  // CTRL bit positions; flush bits are write-only pulses
  localparam int CT_RX_IE     = 0;
  localparam int CT_TXIDLE_IE = 1;
  localparam int CT_TX_FLUSH  = 2;
  localparam int CT_RX_FLUSH  = 3;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_REQ  = 2'd1,
    T_BUSY = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    R_WAIT = 2'd0,
    R_ACK  = 2'd1,
    R_HOLD = 2'd2
  } rx_state_t;

endpackage

// File: rtl/soc_uart_ctrl_if.sv
// soc_uart_ctrl_if: simple register bus between a host and soc_uart_ctrl.
//   addr  [1:0]  word select (DATA, STATUS, CTRL, reserved)
//   wr           write strobe
//   rd           read strobe
//   wdata [31:0] write data
//   rdata [31:0] read data, registered one cycle after rd
interface soc_uart_ctrl_if;

  logic [1:0]  addr;
  logic        wr;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output wr, output rd, output wdata, input rdata);
  modport slave  (input addr, input wr, input rd, input wdata, output rdata);

endinterface

// File: rtl/soc_uart_ctrl_fifo.sv
// soc_fifo: synchronous FIFO used for both TX and RX byte queues.
//   clk, rst     clock and synchronous active-high reset
//   push, din    write request and data (taken when not full, or when a pop frees a slot)
//   pop, dout    read request and head-of-queue data (pop on empty is ignored)
//   flush        empties the queue; wins over a push in the same cycle
//   full, empty  occupancy flags
//   count        number of stored entries, log2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
module soc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a push into a full queue needs
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/soc_uart_ctrl.sv
// soc_uart_ctrl: register front-end for the soc_uart core with TX/RX FIFOs.
//   uclk, res           clock and synchronous active-high reset
//   bus (slave)         DATA / STATUS / CTRL register access, registered rdata
//   start_tx, tx_data   transmit request towards the core, held until accepted
//   tx_empty            core transmitter free (1) / busy (0)
//   rx_full, rx_data    received byte from the core
//   rx_overrun,rx_break core receive error indications
//   ack                 one-cycle acknowledge of a receive event
//   irq                 level interrupt (only with SOC_UART_CTRL_IRQ_EN defined)
// Macro SOC_UART_CTRL_IRQ_EN enables the interrupt enables in CTRL[1:0] and irq.
module soc_uart_ctrl
  import soc_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  uclk,
  input  logic                  res,
  soc_uart_ctrl_if.slave        bus,
  output logic                  start_tx,
  output logic [7:0]            tx_data,
  input  logic                  tx_empty,
  input  logic                  rx_full,
  input  logic [7:0]            rx_data,
  input  logic                  rx_overrun,
  input  logic                  rx_break,
  output logic                  ack,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_data, wr_status, wr_ctrl, rd_data;
  logic          tx_flush, rx_flush;
  logic          tx_fifo_full, tx_fifo_empty, rx_fifo_full, rx_fifo_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] unused_tx_count, unused_rx_count;
  logic          unused_wdata;
  logic          tx_pop, tx_load, rx_push, rx_pop;
  logic          tx_head_gone;
  logic          tx_idle;
  logic [3:0]    sticky, sticky_set, sticky_clr;
  logic [6:0]    status;
  logic [1:0]    ie;
  logic [31:0]   rdata_q;
  tx_state_t     tx_state, tx_next;
  rx_state_t     rx_state, rx_next;

  assign wr_data   = bus.wr && (bus.addr == ADDR_DATA);
  assign wr_status = bus.wr && (bus.addr == ADDR_STATUS);
  assign wr_ctrl   = bus.wr && (bus.addr == ADDR_CTRL);
  assign rd_data   = bus.rd && (bus.addr == ADDR_DATA);
  assign tx_flush  = wr_ctrl && bus.wdata[CT_TX_FLUSH];
  assign rx_flush  = wr_ctrl && bus.wdata[CT_RX_FLUSH];
  assign rx_pop    = rd_data && !rx_fifo_empty;
  assign unused_wdata = ^bus.wdata[31:8];

  soc_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (uclk),
    .rst   (res),
    .push  (wr_data),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (bus.wdata[7:0]),
    .dout  (tx_head),
    .full  (tx_fifo_full),
    .empty (tx_fifo_empty),
    .count (unused_tx_count)
  );

  soc_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (uclk),
    .rst   (res),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_fifo_full),
    .empty (rx_fifo_empty),
    .count (unused_rx_count)
  );

  // TX handshake: the byte is copied into tx_data on entry to T_REQ so it
  // stays stable however long the core takes to accept it; the FIFO entry is
  // only popped once the core drops tx_empty.
  always_comb begin
    tx_next  = tx_state;
    tx_pop   = 1'b0;
    tx_load  = 1'b0;
    start_tx = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tx_fifo_empty && tx_empty) begin
          tx_next = T_REQ;
          tx_load = 1'b1;
        end
      end
      T_REQ: begin
        start_tx = 1'b1;
        if (!tx_empty) begin
          tx_next = T_BUSY;
          tx_pop  = !tx_head_gone;
        end
      end
      T_BUSY: begin
        if (tx_empty) tx_next = T_IDLE;
      end
      default: tx_next = T_IDLE;
    endcase
  end

  // tx_head_gone remembers that a flush already removed the in-flight byte
  // from the FIFO, so acceptance must not pop a newer byte in its place.
  always_ff @(posedge uclk) begin
    if (res) begin
      tx_state     <= T_IDLE;
      tx_data      <= 8'h00;
      tx_head_gone <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_load) tx_data <= tx_head;
      if (tx_next != T_REQ) tx_head_gone <= 1'b0;
      else if (tx_flush)    tx_head_gone <= 1'b1;
    end
  end

  // RX handshake: accept one event in R_WAIT, pulse ack, then wait for the
  // core to release rx_full/rx_break before looking for the next event.
  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    ack     = 1'b0;
    case (rx_state)
      R_WAIT: begin
        if (rx_full || rx_break) begin
          rx_next = R_ACK;
          rx_push = rx_full && !rx_break;
        end
      end
      R_ACK: begin
        ack     = 1'b1;
        rx_next = R_HOLD;
      end
      R_HOLD: begin
        if (!rx_full && !rx_break) rx_next = R_WAIT;
      end
      default: rx_next = R_WAIT;
    endcase
  end

  always_ff @(posedge uclk) begin
    if (res) rx_state <= R_WAIT;
    else     rx_state <= rx_next;
  end

  // sticky order matches STATUS[6:3]: rx_ovf, rx_overrun, rx_break, tx_ovf
  assign sticky_set[0] = rx_push && rx_fifo_full && !rx_pop && !rx_flush;
  assign sticky_set[1] = (rx_state == R_WAIT) && rx_overrun;
  assign sticky_set[2] = (rx_state == R_WAIT) && rx_break;
  assign sticky_set[3] = wr_data && tx_fifo_full && !tx_pop && !tx_flush;
  assign sticky_clr    = wr_status ? bus.wdata[ST_TX_OVF:ST_RX_OVF] : 4'b0000;

  // a new event in the same cycle as a clear wins so it is never lost
  always_ff @(posedge uclk) begin
    if (res) sticky <= 4'b0000;
    else     sticky <= (sticky & ~sticky_clr) | sticky_set;
  end

  assign tx_idle = tx_fifo_empty && (tx_state == T_IDLE);
  assign status  = {sticky, tx_idle, tx_fifo_full, !rx_fifo_empty};

`ifdef SOC_UART_CTRL_IRQ_EN
  always_ff @(posedge uclk) begin
    if (res)          ie <= 2'b00;
    else if (wr_ctrl) ie <= bus.wdata[CT_TXIDLE_IE:CT_RX_IE];
  end

  always_ff @(posedge uclk) begin
    if (res) irq <= 1'b0;
    else     irq <= (ie[CT_RX_IE] && status[ST_RX_AVAIL]) ||
                    (ie[CT_TXIDLE_IE] && tx_idle) ||
                    (ie[CT_RX_IE] && (|sticky[2:0]));
  end
`else
  assign ie  = 2'b00;
  assign irq = 1'b0;
`endif

  // rdata is zero whenever no read was issued in the previous cycle
  always_ff @(posedge uclk) begin
    if (res) begin
      rdata_q <= 32'h0;
    end else if (bus.rd) begin
      case (bus.addr)
        ADDR_DATA:   rdata_q <= {24'h0, (rx_fifo_empty ? 8'h00 : rx_head)};
        ADDR_STATUS: rdata_q <= {25'h0, status};
        ADDR_CTRL:   rdata_q <= {30'h0, ie};
        default:     rdata_q <= 32'h0;
      endcase
    end else begin
      rdata_q <= 32'h0;
    end
  end

  assign bus.rdata = rdata_q;

endmodule
